// File: rtl/acl_spi_responder.sv
// acl_spi_responder: SPI mode-0 register-file slave for an accelerometer front end.
// The SPI pins are synchronized into clk, and edges are detected on the synchronized copies.
// Incoming samples are held back while the slave is selected, so that a burst read
// always returns a consistent X/Y/Z set.
`timescale 1ns/1ps
module acl_spi_responder #(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic        smp_wr,
  input  logic [11:0] smp_x,
  input  logic [11:0] smp_y,
  input  logic [11:0] smp_z,
  output logic        wr_stb,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        cmd_err,
  output logic [7:0]  power_ctl
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] WDATA  = 3'd3;
  localparam logic [2:0] RDATA  = 3'd4;
  localparam logic [2:0] IGNORE = 3'd5;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  // Synchronizers and edge-detect history
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] ss_sync;
  logic       sclk_prev;
  logic       ss_prev;
  logic [1:0] live;
  logic       armed;

  // Protocol state
  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_in;
  logic [7:0] tx_shift;
  logic       is_read;
  logic       load_pend;
  logic [5:0] addr;

  // Register file and pending sample buffer
  logic [7:0]  regs [64];
  logic        pend_valid;
  logic [11:0] pend_x;
  logic [11:0] pend_y;
  logic [11:0] pend_z;

  logic       sclk_s;
  logic       mosi_s;
  logic       ss_s;
  logic       ss_fall;
  logic       ss_rise;
  logic       sclk_rise;
  logic       sclk_fall;
  logic [7:0] byte_in;
  logic       byte_done;
  logic       protect;
  logic       wr_en;
  logic [7:0] rd_val;

  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign ss_s      = ss_sync[1];
  // A falling ss_n only counts once ss_n has been seen high after reset, so a
  // frame that was in progress when reset was released is never resumed.
  assign ss_fall   = armed & ss_prev & ~ss_s;
  assign ss_rise   = ~ss_prev & ss_s;
  assign sclk_rise = sclk_s & ~sclk_prev & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_prev & ~ss_s;
  assign byte_in   = {shift_in[6:0], mosi_s};
  assign byte_done = sclk_rise && (state != IDLE) && (bit_cnt == 3'd7);
  assign protect   = (addr <= 6'h02) || ((addr >= 6'h0E) && (addr <= 6'h13));
  assign wr_en     = byte_done && (state == WDATA) && !protect;

  assign spi_miso_oe = ~ss_s;
  assign power_ctl   = regs[6'h2D];

  // Read-side view of the register map: the ID bytes are fixed, everything else is stored
  always_comb begin
    rd_val = regs[addr];
    case (addr)
      6'h00:   rd_val = DEVID_AD;
      6'h01:   rd_val = DEVID_MST;
      6'h02:   rd_val = PARTID;
      default: ;
    endcase
  end

  // Two-flop synchronizers for the SPI pins, plus the post-reset arming of ss_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      ss_sync   <= 2'b11;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
      live      <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      ss_sync   <= {ss_sync[0], spi_ss_n};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
      live      <= {live[0], 1'b1};
      if (live[1] && ss_s) begin
        armed <= 1'b1;
      end
    end
  end

  // Frame FSM: command/address decode, write strobes and the MISO shifter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_in  <= 8'h00;
      tx_shift  <= 8'h00;
      is_read   <= 1'b0;
      load_pend <= 1'b0;
      addr      <= 6'h00;
      spi_miso  <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= 6'h00;
      wr_data   <= 8'h00;
      cmd_err   <= 1'b0;
    end else begin
      wr_stb  <= 1'b0;
      cmd_err <= 1'b0;
      if (ss_rise) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        load_pend <= 1'b0;
        tx_shift  <= 8'h00;
        spi_miso  <= 1'b0;
      end else if (ss_fall) begin
        state     <= CMD;
        bit_cnt   <= 3'd0;
        load_pend <= 1'b0;
        spi_miso  <= 1'b0;
      end else begin
        if (sclk_rise && (state != IDLE)) begin
          shift_in <= byte_in;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              CMD: begin
                if (byte_in == CMD_WRITE) begin
                  is_read <= 1'b0;
                  state   <= ADDR;
                end else if (byte_in == CMD_READ) begin
                  is_read <= 1'b1;
                  state   <= ADDR;
                end else begin
                  state   <= IGNORE;
                  cmd_err <= 1'b1;
                end
              end
              ADDR: begin
                addr <= byte_in[5:0];
                if (is_read) begin
                  state     <= RDATA;
                  load_pend <= 1'b1;
                end else begin
                  state <= WDATA;
                end
              end
              WDATA: begin
                if (!protect) begin
                  wr_stb  <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= byte_in;
                end
                addr <= addr + 6'd1;
              end
              RDATA:   load_pend <= 1'b1;
              default: ;
            endcase
          end
        end
        if (sclk_fall && (state == RDATA)) begin
          if (load_pend) begin
            tx_shift  <= rd_val;
            spi_miso  <= rd_val[7];
            addr      <= addr + 6'd1;
            load_pend <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            spi_miso <= tx_shift[6];
          end
        end
      end
    end
  end

  // Register storage: SPI writes, direct sample updates and the deferred sample buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) begin
        regs[i] <= 8'h00;
      end
      pend_valid <= 1'b0;
      pend_x     <= 12'h000;
      pend_y     <= 12'h000;
      pend_z     <= 12'h000;
    end else begin
      if (wr_en) begin
        regs[addr] <= byte_in;
      end
      if (smp_wr && ss_s && !ss_rise) begin
        regs[6'h0E] <= smp_x[7:0];
        regs[6'h0F] <= {{4{smp_x[11]}}, smp_x[11:8]};
        regs[6'h10] <= smp_y[7:0];
        regs[6'h11] <= {{4{smp_y[11]}}, smp_y[11:8]};
        regs[6'h12] <= smp_z[7:0];
        regs[6'h13] <= {{4{smp_z[11]}}, smp_z[11:8]};
      end else if (smp_wr) begin
        pend_x     <= smp_x;
        pend_y     <= smp_y;
        pend_z     <= smp_z;
        pend_valid <= 1'b1;
      end else if (pend_valid && ss_s && ss_prev) begin
        regs[6'h0E] <= pend_x[7:0];
        regs[6'h0F] <= {{4{pend_x[11]}}, pend_x[11:8]};
        regs[6'h10] <= pend_y[7:0];
        regs[6'h11] <= {{4{pend_y[11]}}, pend_y[11:8]};
        regs[6'h12] <= pend_z[7:0];
        regs[6'h13] <= {{4{pend_z[11]}}, pend_z[11:8]};
        pend_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acl_spi_responder.sv
// Bench for acl_spi_responder: directed SPI frames with scoreboard queues for
// MISO bytes, write strobes and command-error pulses.
`timescale 1ns/1ps
module tb_acl_spi_responder;

  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_ss_n = 1'b1;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        smp_wr = 1'b0;
  logic [11:0] smp_x = 12'h000;
  logic [11:0] smp_y = 12'h000;
  logic [11:0] smp_z = 12'h000;
  logic        wr_stb;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        cmd_err;
  logic [7:0]  power_ctl;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;

  logic [7:0]  exp_rx_q [$];
  logic [7:0]  act_rx_q [$];
  logic [13:0] exp_wr_q [$];

  acl_spi_responder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_ss_n    (spi_ss_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .smp_wr      (smp_wr),
    .smp_x       (smp_x),
    .smp_y       (smp_y),
    .smp_z       (smp_z),
    .wr_stb      (wr_stb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cmd_err     (cmd_err),
    .power_ctl   (power_ctl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full byte; the received byte and its expected value go to the scoreboard
  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] rx;
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #(HALF);
      spi_sclk = 1'b1;
      rx[i] = spi_miso;
      #(HALF);
      spi_sclk = 1'b0;
    end
    $display("xfer tx=%02h rx=%02h exp=%02h", tx, rx, exp);
    exp_rx_q.push_back(exp);
    act_rx_q.push_back(rx);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      #(HALF);
      spi_sclk = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
    end
    $display("partial tx=%02h bits=%0d", tx, n);
  endtask

  task automatic start_frame();
    @(negedge clk);
    spi_ss_n = 1'b0;
    #(HALF);
  endtask

  task automatic end_frame();
    #(HALF);
    spi_ss_n = 1'b1;
    #(4*HALF);
  endtask

  task automatic pulse_smp(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    @(negedge clk);
    smp_x  = x;
    smp_y  = y;
    smp_z  = z;
    smp_wr = 1'b1;
    @(negedge clk);
    smp_wr = 1'b0;
    $display("sample x=%03h y=%03h z=%03h ss_n=%0b", x, y, z, spi_ss_n);
  endtask

  // MISO byte monitor
  initial begin
    forever begin
      @(negedge clk);
      while (act_rx_q.size() > 0 && exp_rx_q.size() > 0) begin
        logic [7:0] a;
        logic [7:0] e;
        a = act_rx_q.pop_front();
        e = exp_rx_q.pop_front();
        check("miso_byte", {24'h0, a}, {24'h0, e});
      end
    end
  end

  // Write-strobe and command-error monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wr_stb) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_stb_unexpected: got addr=%02h data=%02h required no strobe", wr_addr, wr_data);
        end else begin
          logic [13:0] e;
          e = exp_wr_q.pop_front();
          $display("wr_stb addr=%02h data=%02h", wr_addr, wr_data);
          check("wr_stb_addr_data", {18'h0, wr_addr, wr_data}, {18'h0, e});
        end
      end
      if (cmd_err) begin
        n_checks++;
        if (exp_err == 0) begin
          n_fail++;
          $display("FAIL cmd_err_unexpected: got pulse required none");
        end else begin
          exp_err--;
          $display("cmd_err pulse");
        end
      end
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check("rst_miso", {31'h0, spi_miso}, 32'h0);
    check("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
    check("rst_power_ctl", {24'h0, power_ctl}, 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_oe", {31'h0, spi_miso_oe}, 32'h0);

    // Read ID registers
    start_frame();
    check("sel_oe", {31'h0, spi_miso_oe}, 32'h1);
    xfer(8'h0B, 8'h00);
    xfer(8'h00, 8'h00);
    xfer(8'h00, 8'hAD);
    xfer(8'h00, 8'h1D);
    xfer(8'h00, 8'hF2);
    end_frame();

    // Write burst with auto-increment, then read back
    exp_wr_q.push_back({6'h2C, 8'h13});
    exp_wr_q.push_back({6'h2D, 8'h02});
    start_frame();
    xfer(8'h0A, 8'h00);
    xfer(8'h2C, 8'h00);
    xfer(8'h13, 8'h00);
    xfer(8'h02, 8'h00);
    end_frame();
    check("power_ctl_written", {24'h0, power_ctl}, 32'h02);
    start_frame();
    xfer(8'h0B, 8'h00);
    xfer(8'h2C, 8'h00);
    xfer(8'h00, 8'h13);
    xfer(8'h00, 8'h02);
    end_frame();

    // Sample atomicity across a burst read
    pulse_smp(12'hFFF, 12'h456, 12'h800);
    repeat (3) @(negedge clk);
    start_frame();
    xfer(8'h0B, 8'h00);
    xfer(8'h0E, 8'h00);
    xfer(8'h00, 8'hFF);
    pulse_smp(12'h123, 12'h000, 12'h7FF);
    xfer(8'h00, 8'hFF);
    xfer(8'h00, 8'h56);
    xfer(8'h00, 8'h04);
    xfer(8'h00, 8'h00);
    xfer(8'h00, 8'hF8);
    end_frame();
    start_frame();
    xfer(8'h0B, 8'h00);
    xfer(8'h0E, 8'h00);
    xfer(8'h00, 8'h23);
    xfer(8'h00, 8'h01);
    xfer(8'h00, 8'h00);
    xfer(8'h00, 8'h00);
    xfer(8'h00, 8'hFF);
    xfer(8'h00, 8'h07);
    end_frame();

    // Address wrap onto the protected ID register
    exp_wr_q.push_back({6'h3F, 8'hAA});
    start_frame();
    xfer(8'h0A, 8'h00);
    xfer(8'h3F, 8'h00);
    xfer(8'hAA, 8'h00);
    xfer(8'h55, 8'h00);
    end_frame();
    start_frame();
    xfer(8'h0B, 8'h00);
    xfer(8'h3F, 8'h00);
    xfer(8'h00, 8'hAA);
    xfer(8'h00, 8'hAD);
    end_frame();

    // Abort after five bits of a data byte
    start_frame();
    xfer(8'h0A, 8'h00);
    xfer(8'h20, 8'h00);
    xfer_bits(8'hFF, 5);
    end_frame();
    start_frame();
    xfer(8'h0B, 8'h00);
    xfer(8'h2D, 8'h00);
    xfer(8'h00, 8'h02);
    end_frame();
    start_frame();
    xfer(8'h0B, 8'h00);
    xfer(8'h20, 8'h00);
    xfer(8'h00, 8'h00);
    end_frame();

    // Unknown command
    exp_err++;
    start_frame();
    xfer(8'h0C, 8'h00);
    xfer(8'hFF, 8'h00);
    xfer(8'h55, 8'h00);
    end_frame();
    check("cmd_err_seen", exp_err, 32'h0);

    // Reset in the middle of a read frame
    start_frame();
    xfer(8'h0B, 8'h00);
    xfer_bits(8'h2C, 3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_miso", {31'h0, spi_miso}, 32'h0);
    check("midrst_oe", {31'h0, spi_miso_oe}, 32'h0);
    check("midrst_wr_stb", {31'h0, wr_stb}, 32'h0);
    check("midrst_wr_addr", {26'h0, wr_addr}, 32'h0);
    check("midrst_wr_data", {24'h0, wr_data}, 32'h0);
    check("midrst_cmd_err", {31'h0, cmd_err}, 32'h0);
    check("midrst_power_ctl", {24'h0, power_ctl}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    // ss_n still low from before reset: this byte must not start a frame
    xfer(8'h0C, 8'h00);
    end_frame();
    start_frame();
    xfer(8'h0B, 8'h00);
    xfer(8'h2C, 8'h00);
    xfer(8'h00, 8'h00);
    xfer(8'h00, 8'h00);
    end_frame();

    repeat (20) @(negedge clk);
    check("wr_queue_drained", exp_wr_q.size(), 32'h0);
    check("rx_queue_drained", exp_rx_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acl_spi_responder.md
ACL_SPI_RESPONDER -- requirements
Module: acl_spi_responder

Interface
REQ-001 Parameter DEVID_AD, default 8'hAD, read-only value of register 0x00.
REQ-002 Parameter DEVID_MST, default 8'h1D, read-only value of register 0x01.
REQ-003 Parameter PARTID, default 8'hF2, read-only value of register 0x02.
REQ-004 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 spi_sclk  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-007 spi_mosi  input  1  master-out data, asynchronous.
REQ-008 spi_ss_n  input  1  active-low slave select, asynchronous.
REQ-009 spi_miso  output  1  slave-out data.
REQ-010 spi_miso_oe  output  1  MISO output enable, 1 while selected.
REQ-011 smp_wr  input  1  one-cycle strobe: new X/Y/Z sample.
REQ-012 smp_x, smp_y, smp_z  input  12 each  signed samples.
REQ-013 wr_stb  output  1  one-cycle pulse per accepted SPI register write.
REQ-014 wr_addr  output  6  address of the last accepted write.
REQ-015 wr_data  output  8  data of the last accepted write.
REQ-016 cmd_err  output  1  one-cycle pulse on an unknown command byte.
REQ-017 power_ctl  output  8  current value of register 0x2D.

Function
REQ-018 spi_sclk, spi_mosi and spi_ss_n SHALL each pass a 2-flop synchronizer; edges are detected on the synchronized values; clk >= 8x SCLK frequency.
REQ-019 Protocol SHALL be SPI mode 0, MSB first: MOSI is sampled on a detected SCLK rising edge; MISO changes only on a detected SCLK falling edge.
REQ-020 FSM states SHALL be IDLE, CMD, ADDR, WDATA, RDATA, IGNORE; synchronized ss_n falling moves IDLE->CMD with the bit counter cleared.
REQ-021 CMD: after 8 bits, 0x0A->ADDR (write), 0x0B->ADDR (read), other->IGNORE with a cmd_err pulse.
REQ-022 ADDR: after 8 bits, addr[5:0] is latched from the low 6 bits and bits [7:6] are ignored; the next state is WDATA or RDATA per the command.
REQ-023 WDATA: each complete byte is written to addr, then addr increments; 0x3F wraps to 0x00; the burst length is unbounded.
REQ-024 Writes to 0x00-0x02 and 0x0E-0x13 SHALL be discarded, with no wr_stb; every other address updates the register and pulses wr_stb with wr_addr/wr_data for exactly one cycle, 1 clk after the 8th rising edge is detected.
REQ-025 RDATA: the register at addr is loaded into the TX shift register on the falling edge that follows the last bit of the previous byte.
  - Its MSB drives MISO from that edge.
  - addr increments, with wrap, after each byte is loaded.
REQ-026 MISO SHALL be 0 in IDLE, CMD, ADDR, WDATA and IGNORE.
REQ-027 MISO SHALL update no later than 3 clk cycles after the SCLK falling edge at the pin.
REQ-028 spi_miso_oe SHALL equal the inverted synchronized ss_n.
REQ-029 Register map: 0x00-0x02 IDs.
  - 0x0E/0x0F X low byte/high nibble, sign-extended to 8 bits.
  - 0x10/0x11 Y, same layout.
  - 0x12/0x13 Z, same layout.
  - 0x2D POWER_CTL.
  - All others are 8-bit RW scratch.
REQ-030 smp_wr while ss_n is high SHALL update 0x0E-0x13 on the next clk.
  - smp_wr while ss_n is low is held in a one-deep pending buffer; a later smp_wr overwrites it.
  - The buffer is applied 1 clk after synchronized ss_n rises, so a burst read never mixes samples.
REQ-031 ss_n rising in any state SHALL return the FSM to IDLE and discard any partial byte, with no write and no wr_stb.
REQ-032 SCLK edges while ss_n is high SHALL be ignored.
REQ-033 A simultaneous smp_wr and ss_n rising SHALL take the buffered path; the result is visible on the next transaction.

Reset
REQ-034 reset_n low SHALL asynchronously clear the following to 0:
  - the FSM to IDLE, the counters, addr and the pending buffer;
  - spi_miso, spi_miso_oe, wr_stb, wr_addr, wr_data and cmd_err;
  - all RW registers and power_ctl.
REQ-035 0x00-0x02 SHALL hold the parameter values at all times.
REQ-036 Reset asserted mid-transaction SHALL abort it.
  - After release, the FSM stays in IDLE until a fresh ss_n falling edge.

Verification
REQ-037 Read ID: ss_n low, bytes 0x0B 0x00 xx xx xx -> MISO returns 0xAD 0x1D 0xF2; wr_stb never pulses.
REQ-038 Write burst: 0x0A 0x2C 0x13 0x02 -> wr_stb twice (0x2C/0x13, 0x2D/0x02); power_ctl=0x02; read-back of 0x2C gives 0x13.
REQ-039 Sample atomicity: smp_x=0xFFF, then during a read burst of 0x0E-0x13 smp_wr with smp_x=0x123 -> the burst returns 0xFF 0xFF; the next read returns 0x23 0x01.
REQ-040 Wrap and protection: write 0x0A 0x3F 0xAA 0x55 -> regs 0x3F=0xAA; 0x00 stays 0xAD; exactly one wr_stb.
REQ-041 Abort: ss_n rises after 5 bits of a write data byte -> no wr_stb, FSM IDLE; the next 0x0B 0x2D read is correct.
REQ-042 Unknown command 0x0C -> one cmd_err pulse; MISO stays 0 for the rest of the frame; reset_n pulsed mid-frame -> all outputs 0.
